// File: rtl/wb_cmd_master_if.sv
// Host byte link, Wishbone master bus and status bundle for wb_cmd_master.
// master = the command block, slave = the host link / Wishbone system side.
interface wb_cmd_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_strobe_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, wb_data_i, wb_ack_i,
        output rx_ready, tx_data, tx_valid, wb_addr_o, wb_data_o,
               wb_we_o, wb_cyc_o, wb_strobe_o, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wb_data_i, wb_ack_i,
        input  rx_ready, tx_data, tx_valid, wb_addr_o, wb_data_o,
               wb_we_o, wb_cyc_o, wb_strobe_o, busy
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Decodes host command bytes into one Wishbone transfer and streams back a response.
// Define WB_CMD_MASTER_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES without ack.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clock,
    input logic              reset,
    wb_cmd_master_if.master  bus
);
    localparam int unsigned TW = 16;
    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_RD   = 8'h02;
    localparam logic [7:0] RSP_OK  = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_cnt, w_cnt_nx;
    logic [1:0]  r_last, w_last_nx;
    logic        r_is_wr, w_is_wr_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic [31:0] r_data, w_data_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic [7:0]  r_tx_data, w_tx_data_nx;
    logic        r_tx_valid, w_tx_valid_nx;
    logic        r_rx_ready, w_rx_ready_nx;
    logic        r_cyc, w_cyc_nx;
    logic        r_we, w_we_nx;
    logic        r_busy, w_busy_nx;
    logic        w_rx_fire, w_tx_fire, w_timeout;

    assign w_rx_fire = bus.rx_valid & r_rx_ready;
    assign w_tx_fire = r_tx_valid & bus.tx_ready;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [TW-1:0] r_timer;

    // Timer sits at zero outside BUS so every bus cycle starts counting from zero.
    assign w_timeout = (r_state == S_BUS) && !bus.wb_ack_i &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || (r_state != S_BUS)) r_timer <= '0;
        else if (!bus.wb_ack_i)          r_timer <= r_timer + TW'(1);
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(TW'(TIMEOUT_CYCLES));
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= '0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rdata    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
            r_is_wr    <= w_is_wr_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_rdata    <= w_rdata_nx;
            r_tx_data  <= w_tx_data_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_rx_ready <= w_rx_ready_nx;
            r_cyc      <= w_cyc_nx;
            r_we       <= w_we_nx;
            r_busy     <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_last_nx    = r_last;
        w_is_wr_nx   = r_is_wr;
        w_addr_nx    = r_addr;
        w_data_nx    = r_data;
        w_rdata_nx   = r_rdata;
        w_tx_data_nx = r_tx_data;

        case (r_state)
            S_IDLE: if (w_rx_fire) begin
                w_cnt_nx = '0;
                if ((bus.rx_data == OP_WR) || (bus.rx_data == OP_RD)) begin
                    w_is_wr_nx = (bus.rx_data == OP_WR);
                    w_state_nx = S_ADDR;
                end else begin
                    w_last_nx    = '0;
                    w_tx_data_nx = RSP_ERR;
                    w_state_nx   = S_RESP;
                end
            end
            S_ADDR: if (w_rx_fire) begin
                w_addr_nx = {r_addr[23:0], bus.rx_data};
                w_cnt_nx  = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nx = r_is_wr ? S_DATA : S_BUS;
            end
            S_DATA: if (w_rx_fire) begin
                w_data_nx = {r_data[23:0], bus.rx_data};
                w_cnt_nx  = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nx = S_BUS;
            end
            S_BUS: begin
                // Ack wins over a timeout landing on the same edge.
                if (bus.wb_ack_i) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_RESP;
                    if (r_is_wr) begin
                        w_last_nx    = '0;
                        w_tx_data_nx = RSP_OK;
                    end else begin
                        w_last_nx    = 2'd3;
                        w_rdata_nx   = bus.wb_data_i;
                        w_tx_data_nx = bus.wb_data_i[31:24];
                    end
                end else if (w_timeout) begin
                    w_cnt_nx     = '0;
                    w_last_nx    = '0;
                    w_tx_data_nx = RSP_ERR;
                    w_state_nx   = S_RESP;
                end
            end
            S_RESP: if (w_tx_fire) begin
                if (r_cnt == r_last) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 2'd1;
                    case (r_cnt)
                        2'd0:    w_tx_data_nx = r_rdata[23:16];
                        2'd1:    w_tx_data_nx = r_rdata[15:8];
                        default: w_tx_data_nx = r_rdata[7:0];
                    endcase
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Handshake and bus controls are registered images of the next state.
        w_rx_ready_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_ADDR) ||
                        (w_state_nx == S_DATA);
        w_cyc_nx      = (w_state_nx == S_BUS);
        w_we_nx       = (w_state_nx == S_BUS) && w_is_wr_nx;
        w_tx_valid_nx = (w_state_nx == S_RESP);
        w_busy_nx     = (w_state_nx != S_IDLE);
    end

    assign bus.rx_ready    = r_rx_ready;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.wb_addr_o   = r_addr;
    assign bus.wb_data_o   = r_data;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_strobe_o = r_cyc;
    assign bus.busy        = r_busy;
endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, max cycles to wait for wb_ack_i once strobe is raised (1..65535).
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  command byte from host link.
REQ-005 rx_valid  input  1  rx_data valid; byte transfers when rx_valid & rx_ready at a rising edge.
REQ-006 rx_ready  output  1  block can accept a byte.
REQ-007 tx_data  output  8  response byte to host link.
REQ-008 tx_valid  output  1  tx_data valid; byte transfers when tx_valid & tx_ready.
REQ-009 tx_ready  input  1  host link accepts the byte.
REQ-010 wb_addr_o  output  32  Wishbone address to wb_system.
REQ-011 wb_data_o  output  32  Wishbone write data.
REQ-012 wb_we_o  output  1  1 = write cycle.
REQ-013 wb_cyc_o  output  1  bus cycle active.
REQ-014 wb_strobe_o  output  1  transfer request.
REQ-015 wb_data_i  input  32  read data from wb_system.
REQ-016 wb_ack_i  input  1  transfer acknowledge.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, ADDR, DATA, BUS, RESP; IDLE is the only state with busy low.
REQ-019 IDLE: rx_ready=1; opcode 0x01 (write) or 0x02 (read) -> ADDR, byte count cleared; any other byte -> RESP with single response 0xEE.
REQ-020 ADDR: rx_ready=1; accept exactly 4 bytes, MSB first, into wb_addr_o; after 4th: write -> DATA, read -> BUS.
REQ-021 DATA: rx_ready=1; accept exactly 4 bytes, MSB first, into wb_data_o; after 4th -> BUS.
REQ-022 rx_ready is 0 in BUS and RESP; input bytes are never dropped, only stalled.
REQ-023 BUS: wb_cyc_o=wb_strobe_o=1 from the first cycle in BUS; wb_we_o=1 for write, 0 for read; addr/data/we stable for the whole cycle.
REQ-024 BUS ends in the cycle wb_ack_i is sampled high; cyc/strobe are 0 the following cycle; read latches wb_data_i on that edge.
REQ-025 Minimum BUS duration one cycle (ack present on the first strobe cycle completes the transfer).
REQ-026 RESP: write -> one byte 0xA5; read -> 4 bytes of latched data, MSB first; tx_data held stable while tx_valid=1 and tx_ready=0.
REQ-027 After the last response byte transfers -> IDLE; rx_ready rises the cycle after.
REQ-028 tx_valid is 0 outside RESP.
REQ-029 wb_ack_i outside BUS is ignored.
REQ-030 Consecutive commands: no extra cycles beyond one IDLE cycle between response end and next opcode accept.

Reset
REQ-031 On reset at any cycle, including mid-bus-cycle: state=IDLE, wb_cyc_o=wb_strobe_o=wb_we_o=0, wb_addr_o=wb_data_o=0, tx_valid=0, tx_data=0, rx_ready=0 during reset, busy=0, counters and read latch cleared.
REQ-032 First cycle after reset deasserts: rx_ready=1.

Configuration
REQ-033 Macro WB_CMD_MASTER_TIMEOUT_EN defined: 16-bit counter starts at 0 on BUS entry, increments each BUS cycle without ack; when counter reaches TIMEOUT_CYCLES without ack, cyc/strobe drop next cycle and RESP sends single byte 0xEE (read or write).
REQ-034 Ack in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
REQ-035 Macro undefined: no counter logic; BUS waits indefinitely for wb_ack_i.

Verification
REQ-036 Write: bytes 01 00 01 00 04 DE AD BE EF, ack after 2 cycles -> one cycle with addr=0x00010004, data=0xDEADBEEF, we=1; response A5.
REQ-037 Read: bytes 02 00 00 00 10, wb_data_i=0x0000000A with ack first cycle -> strobe exactly 1 cycle, we=0; response 00 00 00 0A.
REQ-038 Bad opcode 0x7F -> no Wishbone activity; response EE; next valid command succeeds.
REQ-039 Backpressure: tx_ready low 5 cycles mid-read-response -> tx_data stable, no byte lost or duplicated; rx_valid held high during BUS -> no byte accepted.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=8, ack never) -> strobe drops after 8 cycles, response EE; macro off -> strobe held for 1000 cycles, no response.
REQ-041 Reset asserted during BUS with strobe high -> next cycle cyc/strobe=0, busy=0, tx_valid=0; then rx_ready=1.
